// File: rtl/latch_bank_arbiter.sv
// Round-robin write sequencer for a shared D-latch bank (setup / enable / hold per write).
// Latency: Gnt/Lat_D one edge after Req; write occupies EN_CYCLES+3 cycles including IDLE.
// Backpressure: Req is a level held by the client until Done; Clr wins in IDLE. Build option: LATCH_ARB_FIXED_PRIO_EN.
module latch_bank_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int EN_CYCLES = 1
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [NREQ-1:0]         Req,
  input  logic [NREQ*WIDTH-1:0]   Din_bus,
  input  logic                    Clr,
  output logic [NREQ-1:0]         Gnt,
  output logic [NREQ-1:0]         Done,
  output logic [WIDTH-1:0]        Lat_D,
  output logic                    Lat_En,
  output logic                    Lat_Rst,
  output logic                    Busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SETUP,
    S_ENABLE,
    S_HOLD
  } state_t;

  state_t            state_q;
  logic [NREQ-1:0]   gnt_q;
  logic [NREQ-1:0]   done_q;
  logic [WIDTH-1:0]  lat_d_q;
  logic              lat_en_q;
  logic              lat_rst_q;
  logic              busy_q;
  logic [3:0]        cnt_q;

  logic [PW-1:0]     win_d;
  logic [NREQ-1:0]   win_oh_d;
  logic              any_req;

  assign any_req = |Req;

`ifdef LATCH_ARB_FIXED_PRIO_EN
  // Fixed priority: lowest-index requester wins (scan downward so the last hit is the lowest).
  always_comb begin
    win_d = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (Req[PW'(k)]) win_d = PW'(k);
    end
  end
`else
  logic [PW-1:0]     ptr_q;

  // Round-robin: first requester at or above the pointer, wrapping; scan far-to-near so nearest wins.
  always_comb begin
    int idx;
    win_d = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (Req[PW'(idx)]) win_d = PW'(idx);
    end
  end
`endif

  // One-hot form of the winner, loaded into Gnt on the grant edge.
  always_comb begin
    win_oh_d        = '0;
    win_oh_d[win_d] = 1'b1;
  end

  // Write sequencer: state and every output are registered here together.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      done_q    <= '0;
      lat_d_q   <= '0;
      lat_en_q  <= 1'b0;
      lat_rst_q <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
`ifndef LATCH_ARB_FIXED_PRIO_EN
      ptr_q     <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Clr) begin
            state_q   <= S_CLEAR;
            lat_rst_q <= 1'b1;
            busy_q    <= 1'b1;
          end else if (any_req) begin
            state_q <= S_SETUP;
            gnt_q   <= win_oh_d;
            // Data is captured here so the client is free to change it afterwards.
            lat_d_q <= Din_bus[int'(win_d)*WIDTH +: WIDTH];
            busy_q  <= 1'b1;
`ifndef LATCH_ARB_FIXED_PRIO_EN
            ptr_q   <= (int'(win_d) == NREQ - 1) ? '0 : win_d + 1'b1;
`endif
          end
        end
        S_CLEAR: begin
          state_q   <= S_IDLE;
          lat_rst_q <= 1'b0;
          busy_q    <= 1'b0;
        end
        S_SETUP: begin
          state_q  <= S_ENABLE;
          lat_en_q <= 1'b1;
          cnt_q    <= 4'(EN_CYCLES - 1);
        end
        S_ENABLE: begin
          if (cnt_q == 4'd0) begin
            state_q  <= S_HOLD;
            lat_en_q <= 1'b0;
            done_q   <= gnt_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_HOLD: begin
          state_q <= S_IDLE;
          done_q  <= '0;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q   <= S_IDLE;
          gnt_q     <= '0;
          done_q    <= '0;
          lat_en_q  <= 1'b0;
          lat_rst_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign Gnt     = gnt_q;
  assign Done    = done_q;
  assign Lat_D   = lat_d_q;
  assign Lat_En  = lat_en_q;
  assign Lat_Rst = lat_rst_q;
  assign Busy    = busy_q;

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Bench for latch_bank_arbiter: two instances (EN_CYCLES=1 and 3) share one stimulus stream.
// Expected outputs come from a per-transaction timeline model (phase count since grant).
// Honors LATCH_ARB_FIXED_PRIO_EN in the model when defined.
module tb_latch_bank_arbiter;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Clr = 1'b0;
  logic [3:0]  Req = '0;
  logic [31:0] Din_bus = '0;

  logic [3:0] gnt1, done1, gnt3, done3;
  logic [7:0] latd1, latd3;
  logic       laten1, latrst1, busy1, laten3, latrst3, busy3;

  int vectors = 0;
  int miscompares = 0;

  latch_bank_arbiter #(.NREQ(4), .WIDTH(8), .EN_CYCLES(1)) u_dut1 (
    .Clk(Clk), .Rst(Rst), .Req(Req), .Din_bus(Din_bus), .Clr(Clr),
    .Gnt(gnt1), .Done(done1), .Lat_D(latd1), .Lat_En(laten1), .Lat_Rst(latrst1), .Busy(busy1)
  );

  latch_bank_arbiter #(.NREQ(4), .WIDTH(8), .EN_CYCLES(3)) u_dut3 (
    .Clk(Clk), .Rst(Rst), .Req(Req), .Din_bus(Din_bus), .Clr(Clr),
    .Gnt(gnt3), .Done(done3), .Lat_D(latd3), .Lat_En(laten3), .Lat_Rst(latrst3), .Busy(busy3)
  );

  always #5 Clk = ~Clk;

  // Reference model: per instance, phase = cycles since the grant/clear edge, -1 when idle.
  int         m_phase [2];
  bit         m_clr   [2];
  int         m_win   [2];
  logic [7:0] m_d     [2];
  int         m_ptr   [2];
  int         en_of   [2] = '{1, 3};

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = -1; m_clr[i] = 0; m_win[i] = 0; m_d[i] = '0; m_ptr[i] = 0;
    end
  endtask

  task automatic model_update();
    int w;
    if (Rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      if (m_phase[i] < 0) begin
        if (Clr) begin
          m_clr[i] = 1; m_phase[i] = 0;
        end else if (Req != 0) begin
          w = -1;
`ifdef LATCH_ARB_FIXED_PRIO_EN
          for (int k = 0; k < 4; k++) if (w < 0 && Req[k]) w = k;
`else
          for (int k = 0; k < 4; k++) if (w < 0 && Req[(m_ptr[i] + k) % 4]) w = (m_ptr[i] + k) % 4;
          m_ptr[i] = (w + 1) % 4;
`endif
          m_clr[i] = 0; m_win[i] = w; m_phase[i] = 0;
          m_d[i] = Din_bus[w*8 +: 8];
        end
      end else if (m_phase[i] == (m_clr[i] ? 0 : en_of[i] + 1)) begin
        m_phase[i] = -1;
      end else begin
        m_phase[i]++;
      end
    end
  endtask

  // {Gnt, Done, Lat_D, Lat_En, Lat_Rst, Busy}
  function automatic logic [18:0] exp_vec(int i);
    logic [3:0] g, d;
    logic en, r, b;
    g = '0; d = '0; en = 0; r = 0; b = 0;
    if (m_phase[i] >= 0) begin
      b = 1;
      if (m_clr[i]) r = 1;
      else begin
        g = 4'b0001 << m_win[i];
        en = (m_phase[i] >= 1 && m_phase[i] <= en_of[i]);
        if (m_phase[i] == en_of[i] + 1) d = g;
      end
    end
    return {g, d, m_d[i], en, r, b};
  endfunction

  task automatic step();
    @(posedge Clk);
    model_update();
    @(negedge Clk);
  endtask

  task automatic do_reset();
    Rst = 1'b1; Req = '0; Clr = 1'b0;
    model_reset();
    step();
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1; Req = '0; Clr = 1'b0; Din_bus = 32'hFFFF_FFFF;
    model_reset();
    #1;
    vectors++;
    if ({gnt1, done1, latd1, laten1, latrst1, busy1} !== 19'd0 ||
        {gnt3, done3, latd3, laten3, latrst3, busy3} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_assert: dut1=%h dut3=%h required 0", {gnt1, done1, latd1, laten1, latrst1, busy1},
               {gnt3, done3, latd3, laten3, latrst3, busy3});
    end
    step();
    Rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      vectors++;
      if ({gnt1, done1, latd1, laten1, latrst1, busy1} !== 19'd0 ||
          {gnt3, done3, latd3, laten3, latrst3, busy3} !== 19'd0) begin
        miscompares++;
        $display("FAIL reset_idle c%0d: dut1=%h dut3=%h required 0", c, {gnt1, done1, latd1, laten1, latrst1, busy1},
                 {gnt3, done3, latd3, laten3, latrst3, busy3});
      end
    end
  endtask

  task automatic test_single_write();
    do_reset();
    Req = 4'b0001; Din_bus = 32'h1234_56A5;
    step();
    vectors++;
    if ({gnt1, latd1, laten1, done1, busy1} !== {4'b0001, 8'hA5, 1'b0, 4'b0000, 1'b1}) begin
      miscompares++;
      $display("FAIL single_setup: gnt=%b d=%h en=%b done=%b busy=%b required 0001 a5 0 0000 1", gnt1, latd1, laten1, done1, busy1);
    end
    Din_bus[7:0] = 8'h00;
    step();
    vectors++;
    if ({gnt1, latd1, laten1, done1} !== {4'b0001, 8'hA5, 1'b1, 4'b0000}) begin
      miscompares++;
      $display("FAIL single_enable: gnt=%b d=%h en=%b done=%b required 0001 a5 1 0000", gnt1, latd1, laten1, done1);
    end
    step();
    vectors++;
    if ({gnt1, latd1, laten1, done1} !== {4'b0001, 8'hA5, 1'b0, 4'b0001}) begin
      miscompares++;
      $display("FAIL single_hold: gnt=%b d=%h en=%b done=%b required 0001 a5 0 0001", gnt1, latd1, laten1, done1);
    end
    Req = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      step();
      vectors++;
      if ({gnt1, laten1, done1, busy1, latd1} !== {4'b0000, 1'b0, 4'b0000, 1'b0, 8'hA5}) begin
        miscompares++;
        $display("FAIL single_idle c%0d: gnt=%b en=%b done=%b busy=%b d=%h required 0000 0 0000 0 a5", c, gnt1, laten1, done1, busy1, latd1);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] want;
    do_reset();
    Req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      step();
`ifdef LATCH_ARB_FIXED_PRIO_EN
      want = 4'b0001;
`else
      want = 4'b0001 << (n % 4);
`endif
      vectors++;
      if (gnt1 !== want) begin
        miscompares++;
        $display("FAIL round_robin write%0d: gnt=%b required %b", n, gnt1, want);
      end
      step(); step(); step();
    end
    Req = 4'b0000;
  endtask

  task automatic test_clear_priority();
    do_reset();
    Clr = 1'b1; Req = 4'b0010;
    step();
    vectors++;
    if ({latrst1, gnt1, laten1, busy1} !== {1'b1, 4'b0000, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL clear_pulse: rst=%b gnt=%b en=%b busy=%b required 1 0000 0 1", latrst1, gnt1, laten1, busy1);
    end
    Clr = 1'b0;
    step();
    vectors++;
    if ({latrst1, gnt1, busy1} !== {1'b0, 4'b0000, 1'b0}) begin
      miscompares++;
      $display("FAIL clear_idle: rst=%b gnt=%b busy=%b required 0 0000 0", latrst1, gnt1, busy1);
    end
    step();
    vectors++;
    if (gnt1 !== 4'b0010) begin
      miscompares++;
      $display("FAIL clear_then_grant: gnt=%b required 0010", gnt1);
    end
    Req = 4'b0000;
    step(); step();
    vectors++;
    if (done1 !== 4'b0010) begin
      miscompares++;
      $display("FAIL req_drop_no_abort: done=%b required 0010", done1);
    end
  endtask

  task automatic test_en_cycles3();
    logic [7:0] en_pat, done_pat;
    en_pat = '0; done_pat = '0;
    do_reset();
    Req = 4'b0001; Din_bus = 32'h0000_003C;
    for (int s = 1; s < 8; s++) begin
      step();
      if (s == 1) begin
        vectors++;
        if ({gnt3, latd3} !== {4'b0001, 8'h3C}) begin
          miscompares++;
          $display("FAIL en3_grant: gnt=%b d=%h required 0001 3c", gnt3, latd3);
        end
        Din_bus = '0;
      end
      en_pat[s]   = laten3;
      done_pat[s] = done3[0];
      if (s == 5) Req = 4'b0000;
    end
    vectors++;
    if (en_pat !== 8'b0001_1100) begin
      miscompares++;
      $display("FAIL en3_enable_window: pattern=%b required 00011100", en_pat);
    end
    vectors++;
    if (done_pat !== 8'b0010_0000) begin
      miscompares++;
      $display("FAIL en3_done_timing: pattern=%b required 00100000", done_pat);
    end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    Req = 4'b0011; Din_bus = 32'h0000_5A5A;
    step();
    step();
    vectors++;
    if (laten1 !== 1'b1 || laten3 !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_pre: en1=%b en3=%b required 1 1", laten1, laten3);
    end
    #2;
    Rst = 1'b1;
    model_reset();
    #1;
    vectors++;
    if ({laten1, gnt1, busy1, laten3, gnt3, busy3, latd1} !== 15'd0) begin
      miscompares++;
      $display("FAIL midrst_async: en1=%b gnt1=%b busy1=%b en3=%b gnt3=%b busy3=%b d1=%h required all 0",
               laten1, gnt1, busy1, laten3, gnt3, busy3, latd1);
    end
    step();
    vectors++;
    if (done1 !== 4'b0000 || done3 !== 4'b0000) begin
      miscompares++;
      $display("FAIL midrst_no_done: done1=%b done3=%b required 0000", done1, done3);
    end
    Rst = 1'b0;
    step();
    vectors++;
    if (gnt1 !== 4'b0001 || gnt3 !== 4'b0001) begin
      miscompares++;
      $display("FAIL midrst_ptr_reset: gnt1=%b gnt3=%b required 0001", gnt1, gnt3);
    end
    Req = 4'b0000;
  endtask

  task automatic test_random();
    logic [18:0] a1, a3, e1, e3;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      Req     = 4'($urandom_range(0, 15));
      Clr     = ($urandom_range(0, 9) == 0);
      Din_bus = $urandom;
      Rst     = ($urandom_range(0, 99) == 0);
      step();
      a1 = {gnt1, done1, latd1, laten1, latrst1, busy1};
      a3 = {gnt3, done3, latd3, laten3, latrst3, busy3};
      e1 = exp_vec(0);
      e3 = exp_vec(1);
      vectors++;
      if (a1 !== e1) begin
        miscompares++;
        $display("FAIL random_en1 c%0d: got gnt/done/d/en/rst/busy=%h required %h", c, a1, e1);
      end
      vectors++;
      if (a3 !== e3) begin
        miscompares++;
        $display("FAIL random_en3 c%0d: got gnt/done/d/en/rst/busy=%h required %h", c, a3, e3);
      end
    end
    Rst = 1'b0; Req = '0; Clr = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge Clk);
    test_reset();
    test_single_write();
    test_round_robin();
    test_clear_priority();
    test_en_cycles3();
    test_reset_mid_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
